// File: rtl/beta_mem_arbiter_if.sv
// rtl/beta_mem_arbiter_if.sv - Beta port, laser-fetch port and single-port RAM signal bundle
interface beta_mem_arbiter_if #(
  parameter int ADDR_W = 14
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [31:0]       a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [31:0]       a_rdata;

  logic              b_req;
  logic [ADDR_W-1:0] b_addr;
  logic              b_gnt;
  logic              b_rvalid;
  logic [31:0]       b_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_addr, ram_dout,
    output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
    output ram_en, ram_we, ram_addr, ram_din
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_addr, ram_dout,
    input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
    input  ram_en, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/beta_mem_arbiter.sv
// rtl/beta_mem_arbiter.sv - two-port arbiter onto a 1-cycle-latency single-port RAM
// Optional Port B starvation guard enabled by macro BETA_ARB_STARVE_GUARD_EN.
module beta_mem_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  beta_mem_arbiter_if.slave   bus
);

  logic              w_b_prio;
  logic              w_b_win;
  logic              w_a_gnt;
  logic              w_b_gnt;
  logic [ADDR_W-1:0] w_ram_addr;
  logic              r_a_rd;
  logic              r_b_rd;

`ifdef BETA_ARB_STARVE_GUARD_EN
  localparam int LP_CNT_W = $clog2(MAX_WAIT + 1);

  logic [LP_CNT_W-1:0] r_wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (w_b_gnt || !bus.b_req) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != LP_CNT_W'(MAX_WAIT)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign w_b_prio = (r_wait_cnt == LP_CNT_W'(MAX_WAIT));
`else
  logic w_unused_max_wait;
  assign w_unused_max_wait = (MAX_WAIT != 0);
  assign w_b_prio          = 1'b0;
`endif

  // Grants are gated by rst_n so reset silences the RAM port without waiting for a clock.
  assign w_b_win = bus.b_req & (~bus.a_req | w_b_prio);
  assign w_a_gnt = rst_n & bus.a_req & ~w_b_win;
  assign w_b_gnt = rst_n & w_b_win;

  assign w_ram_addr   = w_b_gnt ? bus.b_addr : bus.a_addr;
  assign bus.a_gnt    = w_a_gnt;
  assign bus.b_gnt    = w_b_gnt;
  assign bus.ram_en   = w_a_gnt | w_b_gnt;
  assign bus.ram_we   = w_a_gnt & bus.a_we;
  assign bus.ram_addr = w_ram_addr;
  assign bus.ram_din  = bus.a_wdata;

  // Owner pipeline: one flag per port tracks the read whose data lands on ram_dout next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_rd <= 1'b0;
      r_b_rd <= 1'b0;
    end else begin
      r_a_rd <= w_a_gnt & ~bus.a_we;
      r_b_rd <= w_b_gnt;
    end
  end

  assign bus.a_rvalid = r_a_rd;
  assign bus.b_rvalid = r_b_rd;
  assign bus.a_rdata  = bus.ram_dout;
  assign bus.b_rdata  = bus.ram_dout;

endmodule

// File: tb/tb_beta_mem_arbiter.sv
// tb/tb_beta_mem_arbiter.sv - directed self-checking bench for beta_mem_arbiter
module tb_beta_mem_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   n_gnt;
  int   n_rv;
  logic exp_b;

  logic [31:0] mem [0:16383];
  bit          wr  [0:16383];

  beta_mem_arbiter_if #(.ADDR_W(14)) bus ();

  beta_mem_arbiter #(.ADDR_W(14), .MAX_WAIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [13:0] a);
    if (a == 14'h010)      return 32'hDEADBEEF;
    else if (a == 14'h011) return 32'hB0B00011;
    else                   return 32'hC0DE0000 | {18'd0, a};
  endfunction

  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) begin
        mem[bus.ram_addr] <= bus.ram_din;
        wr[bus.ram_addr]  <= 1'b1;
      end else begin
        bus.ram_dout <= wr[bus.ram_addr] ? mem[bus.ram_addr] : init_word(bus.ram_addr);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_a_gnt"}, {31'd0, bus.a_gnt}, 32'd0);
    chk({tag, "_b_gnt"}, {31'd0, bus.b_gnt}, 32'd0);
    chk({tag, "_ram_en"}, {31'd0, bus.ram_en}, 32'd0);
    chk({tag, "_ram_we"}, {31'd0, bus.ram_we}, 32'd0);
    chk({tag, "_a_rvalid"}, {31'd0, bus.a_rvalid}, 32'd0);
    chk({tag, "_b_rvalid"}, {31'd0, bus.b_rvalid}, 32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 14'h010; bus.a_wdata = 32'h0;
    bus.b_req = 1'b1; bus.b_addr = 14'h011;
    #2;
    chk_quiet("rst");

    @(negedge clk);
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.b_req = 1'b0;
    rst_n = 1'b1;

    // Lone A read, same-cycle grant, data one cycle later
    @(negedge clk);
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 14'h010;
    #1;
    chk("a_rd_gnt", {31'd0, bus.a_gnt}, 32'd1);
    chk("a_rd_bgnt", {31'd0, bus.b_gnt}, 32'd0);
    chk("a_rd_en", {31'd0, bus.ram_en}, 32'd1);
    chk("a_rd_we", {31'd0, bus.ram_we}, 32'd0);
    chk("a_rd_addr", {18'd0, bus.ram_addr}, 32'h010);
    @(posedge clk); #1;
    chk("a_rd_rvalid", {31'd0, bus.a_rvalid}, 32'd1);
    chk("a_rd_rdata", bus.a_rdata, 32'hDEADBEEF);
    chk("a_rd_b_rvalid", {31'd0, bus.b_rvalid}, 32'd0);
    @(negedge clk);
    bus.a_req = 1'b0;

    // Collision: A wins, B follows next cycle
    @(negedge clk);
    bus.a_req = 1'b1; bus.b_req = 1'b1; bus.b_addr = 14'h011;
    #1;
    chk("col_a_gnt", {31'd0, bus.a_gnt}, 32'd1);
    chk("col_b_gnt", {31'd0, bus.b_gnt}, 32'd0);
    @(negedge clk);
    bus.a_req = 1'b0;
    #1;
    chk("col_b_gnt2", {31'd0, bus.b_gnt}, 32'd1);
    chk("col_a_gnt2", {31'd0, bus.a_gnt}, 32'd0);
    chk("col_b_addr", {18'd0, bus.ram_addr}, 32'h011);
    chk("col_a_rvalid", {31'd0, bus.a_rvalid}, 32'd1);
    @(posedge clk); #1;
    chk("col_b_rvalid", {31'd0, bus.b_rvalid}, 32'd1);
    chk("col_b_rdata", bus.b_rdata, 32'hB0B00011);
    chk("col_a_rvalid2", {31'd0, bus.a_rvalid}, 32'd0);
    @(negedge clk);
    bus.b_req = 1'b0;

    // Continuous A with B pending: starvation guard behaviour
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 14'h020;
        bus.b_req = 1'b1; bus.b_addr = 14'h021;
      end
      #1;
`ifdef BETA_ARB_STARVE_GUARD_EN
      exp_b = (c == 5);
`else
      exp_b = 1'b0;
`endif
      chk("starve_b_gnt", {31'd0, bus.b_gnt}, {31'd0, exp_b});
      chk("starve_a_gnt", {31'd0, bus.a_gnt}, {31'd0, ~exp_b});
    end
    @(negedge clk);
    bus.a_req = 1'b0; bus.b_req = 1'b0;

    // Write to top address, then B reads it back
    @(negedge clk);
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 14'h3FFF; bus.a_wdata = 32'h12345678;
    #1;
    chk("wr_a_gnt", {31'd0, bus.a_gnt}, 32'd1);
    chk("wr_ram_we", {31'd0, bus.ram_we}, 32'd1);
    chk("wr_ram_din", bus.ram_din, 32'h12345678);
    chk("wr_ram_addr", {18'd0, bus.ram_addr}, 32'h3FFF);
    @(posedge clk); #1;
    chk("wr_no_rvalid", {31'd0, bus.a_rvalid}, 32'd0);
    @(negedge clk);
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.b_req = 1'b1; bus.b_addr = 14'h3FFF;
    #1;
    chk("wrb_b_gnt", {31'd0, bus.b_gnt}, 32'd1);
    chk("wrb_ram_we", {31'd0, bus.ram_we}, 32'd0);
    @(posedge clk); #1;
    chk("wrb_b_rvalid", {31'd0, bus.b_rvalid}, 32'd1);
    chk("wrb_b_rdata", bus.b_rdata, 32'h12345678);
    chk("wrb_a_rvalid", {31'd0, bus.a_rvalid}, 32'd0);
    @(negedge clk);
    bus.b_req = 1'b0;

    // Alternating A/B reads, one per cycle
    n_gnt = 0;
    n_rv  = 0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.a_req  = (i % 2 == 0);
      bus.b_req  = (i % 2 == 1);
      bus.a_addr = 14'(i);
      bus.b_addr = 14'(i);
      #1;
      chk("alt_a_gnt", {31'd0, bus.a_gnt}, {31'd0, (i % 2 == 0)});
      chk("alt_b_gnt", {31'd0, bus.b_gnt}, {31'd0, (i % 2 == 1)});
      if (bus.a_gnt || bus.b_gnt) n_gnt++;
      if (i > 0) begin
        chk("alt_a_rvalid", {31'd0, bus.a_rvalid}, {31'd0, ((i - 1) % 2 == 0)});
        chk("alt_b_rvalid", {31'd0, bus.b_rvalid}, {31'd0, ((i - 1) % 2 == 1)});
        chk("alt_rdata", bus.a_rdata, 32'hC0DE0000 + 32'(i - 1));
        if (bus.a_rvalid || bus.b_rvalid) n_rv++;
      end
      @(negedge clk);
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    #1;
    chk("alt_last_b_rvalid", {31'd0, bus.b_rvalid}, 32'd1);
    chk("alt_last_rdata", bus.b_rdata, 32'hC0DE0007);
    if (bus.a_rvalid || bus.b_rvalid) n_rv++;
    chk("alt_n_gnt", 32'(n_gnt), 32'd8);
    chk("alt_n_rv", 32'(n_rv), 32'd8);

    // Reset right after a B grant clears rvalid asynchronously
    @(negedge clk);
    bus.b_req = 1'b1; bus.b_addr = 14'h005;
    #1;
    chk("rst1_b_gnt", {31'd0, bus.b_gnt}, 32'd1);
    @(posedge clk); #1;
    chk("rst1_b_rvalid", {31'd0, bus.b_rvalid}, 32'd1);
    bus.a_req = 1'b1; bus.a_we = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk_quiet("rst1");

    // Reset asserted inside a B grant cycle discards the read
    @(negedge clk);
    bus.a_req = 1'b0; bus.a_we = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rst2_b_gnt", {31'd0, bus.b_gnt}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_quiet("rst2");
    @(posedge clk); #1;
    chk("rst2_hold_b_rvalid", {31'd0, bus.b_rvalid}, 32'd0);
    @(negedge clk);
    bus.b_req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst2_post_b_rvalid", {31'd0, bus.b_rvalid}, 32'd0);
    chk("rst2_post_a_rvalid", {31'd0, bus.a_rvalid}, 32'd0);

    // Arbitration resumes immediately after release
    @(negedge clk);
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 14'h010;
    #1;
    chk("resume_a_gnt", {31'd0, bus.a_gnt}, 32'd1);
    @(posedge clk); #1;
    chk("resume_a_rvalid", {31'd0, bus.a_rvalid}, 32'd1);
    chk("resume_a_rdata", bus.a_rdata, 32'hDEADBEEF);
    @(negedge clk);
    bus.a_req = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
